// File: rtl/uart_tx_if.sv
// Byte-stream handshake and serial-line status bundle for uart_tx.
// The producer uses the master side and uart_tx uses the slave side.
interface uart_tx_if;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic       o_tx;
  logic       o_busy;
  logic       o_done;

  modport master (
    output i_data,
    output i_valid,
    input  o_ready,
    input  o_tx,
    input  o_busy,
    input  o_done
  );

  modport slave (
    input  i_data,
    input  i_valid,
    output o_ready,
    output o_tx,
    output o_busy,
    output o_done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter with a small FIFO: 8N1 framing, LSB first, registered line output.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx #(
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100000000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic     i_clk_uart,
  input  logic     i_rst,
  uart_tx_if.slave bus
);
  localparam int CLK_DIV = CLK_FREQ / BAUD_RATE;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam logic [15:0]      BIT_LAST = 16'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_START  = 3'b001,
    S_DATA   = 3'b010,
`ifdef UART_TX_PARITY_EN
    S_STOP   = 3'b011,
    S_PARITY = 3'b100
`else
    S_STOP   = 3'b011
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             push, pop, bit_end;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // Ready is forced low during reset so nothing is enqueued while i_rst is high.
  assign bus.o_ready = ~i_rst & (count_q != FULL_CNT);
  assign bus.o_tx    = tx_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;

  always_comb begin
    push      = bus.i_valid & bus.o_ready;
    pop       = (state_q == S_IDLE) && (count_q != '0);
    bit_end   = (bit_cnt_q == BIT_LAST);
    state_d   = state_q;
    bit_cnt_d = bit_end ? 16'd0 : bit_cnt_q + 16'd1;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    done_d    = 1'b0;
    wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        bit_cnt_d = 16'd0;
        if (pop) begin
          state_d = S_START;
          shreg_d = fifo_mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
          parity_d = ^fifo_mem_q[rd_ptr_q];
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_d   = {1'b0, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level follows the current state, so o_tx lags the state by one cycle.
    case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_q[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_q;
`endif
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE) || (count_d != '0) || done_d;
  end

  always_ff @(posedge i_clk_uart) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 16'd0;
      bit_idx_q <= 3'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by the control flops.
  always_ff @(posedge i_clk_uart) begin
    shreg_q <= shreg_d;
`ifdef UART_TX_PARITY_EN
    parity_q <= parity_d;
`endif
    if (push) fifo_mem_q[wr_ptr_q] <= bus.i_data;
  end
endmodule
